// File: rtl/mips_fetch_controller_if.sv
// Fetch-side bus between the MIPS core, mips_fetch_controller and the instruction memory.
// The controller takes the slave modport; the core/memory side takes the master modport.
interface mips_fetch_controller_if;
  logic         FetchRequest;
  logic [31:0]  FetchAddress;
  logic         FetchFlush;
  logic [31:0]  InstructionOut;
  logic         InstructionValid;
  logic         FetchBusy;
  logic [31:0]  MemAddress;
  logic [127:0] MemLine;

  modport master (
    output FetchRequest, FetchAddress, FetchFlush, MemLine,
    input  InstructionOut, InstructionValid, FetchBusy, MemAddress
  );

  modport slave (
    input  FetchRequest, FetchAddress, FetchFlush, MemLine,
    output InstructionOut, InstructionValid, FetchBusy, MemAddress
  );
endinterface

// File: rtl/mips_fetch_controller.sv
// Instruction-fetch sequencer with a single 128-bit line buffer in front of Mips_Instruction_Memory.
// Optional hit/miss performance counters are built when FETCH_PERF_COUNT_EN is defined.
module mips_fetch_controller #(
  parameter int MEM_LATENCY = 1
) (
  input  logic                    ClockPulse,
  input  logic                    Reset,
  mips_fetch_controller_if.slave  fetchBus
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [15:0]             HitCount,
  output logic [15:0]             MissCount
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY);

  logic [1:0]   state_r;
  logic [27:0]  lineTag_r;
  logic [127:0] lineData_r;
  logic         lineValid_r;
  logic [1:0]   wordIdx_r;
  logic [3:0]   latCnt_r;
  logic [31:0]  instrOut_r;
  logic         instrValid_r;
  logic         busy_r;
  logic [31:0]  memAddr_r;
  logic         accept_s;
  logic         hit_s;

  function automatic logic [31:0] selectWord(input logic [127:0] line, input logic [1:0] idx);
    logic [31:0] word;
    case (idx)
      2'd0:    word = line[31:0];
      2'd1:    word = line[63:32];
      2'd2:    word = line[95:64];
      2'd3:    word = line[127:96];
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  // Request acceptance and line-buffer hit detection
  always_comb begin
    accept_s = 1'b0;
    hit_s    = 1'b0;
    if ((state_r == IDLE) && fetchBus.FetchRequest && !fetchBus.FetchFlush) begin
      accept_s = 1'b1;
      hit_s    = lineValid_r && (lineTag_r == fetchBus.FetchAddress[31:4]);
    end else begin
      accept_s = 1'b0;
      hit_s    = 1'b0;
    end
  end

  // Fetch FSM, line buffer and registered outputs; flush outranks everything but reset
  always_ff @(posedge ClockPulse) begin
    if (Reset) begin
      state_r      <= IDLE;
      lineTag_r    <= 28'h000_0000;
      lineData_r   <= 128'h0;
      lineValid_r  <= 1'b0;
      wordIdx_r    <= 2'd0;
      latCnt_r     <= 4'd0;
      instrOut_r   <= 32'h0000_0000;
      instrValid_r <= 1'b0;
      busy_r       <= 1'b0;
      memAddr_r    <= 32'h0000_0000;
    end else begin
      instrValid_r <= 1'b0;
      if (fetchBus.FetchFlush) begin
        lineValid_r <= 1'b0;
        state_r     <= IDLE;
        busy_r      <= 1'b0;
        latCnt_r    <= 4'd0;
      end else begin
        case (state_r)
          IDLE: begin
            if (accept_s) begin
              if (hit_s) begin
                instrOut_r   <= selectWord(lineData_r, fetchBus.FetchAddress[3:2]);
                instrValid_r <= 1'b1;
              end else begin
                memAddr_r <= {fetchBus.FetchAddress[31:4], 4'h0};
                wordIdx_r <= fetchBus.FetchAddress[3:2];
                latCnt_r  <= LAT_LOAD;
                busy_r    <= 1'b1;
                state_r   <= WAIT;
              end
            end
          end
          WAIT: begin
            latCnt_r <= latCnt_r - 4'd1;
            if (latCnt_r <= 4'd1) begin
              state_r <= FILL;
            end
          end
          FILL: begin
            lineData_r   <= fetchBus.MemLine;
            lineTag_r    <= memAddr_r[31:4];
            lineValid_r  <= 1'b1;
            instrOut_r   <= selectWord(fetchBus.MemLine, wordIdx_r);
            instrValid_r <= 1'b1;
            busy_r       <= 1'b0;
            latCnt_r     <= 4'd0;
            state_r      <= IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign fetchBus.InstructionOut   = instrOut_r;
  assign fetchBus.InstructionValid = instrValid_r;
  assign fetchBus.FetchBusy        = busy_r;
  assign fetchBus.MemAddress       = memAddr_r;

`ifdef FETCH_PERF_COUNT_EN
  // Each accepted request bumps exactly one counter; aborted misses already counted here
  always_ff @(posedge ClockPulse) begin
    if (Reset) begin
      HitCount  <= 16'h0000;
      MissCount <= 16'h0000;
    end else if (accept_s) begin
      if (hit_s) begin
        HitCount <= HitCount + 16'h0001;
      end else begin
        MissCount <= MissCount + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_fetch_controller.sv
// Bench for mips_fetch_controller: two instances (MEM_LATENCY 1 and 4) share one stimulus stream
// and are compared every cycle against a time-based reference model of the fetch rules.
module tb_mips_fetch_controller;

  logic        clk;
  logic        rst;
  logic        req;
  logic        flush;
  logic [31:0] addr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mips_fetch_controller_if busA ();
  mips_fetch_controller_if busB ();

`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] hitA, missA, hitB, missB;
`endif

  mips_fetch_controller #(.MEM_LATENCY(1)) dutA (
    .ClockPulse (clk),
    .Reset      (rst),
    .fetchBus   (busA)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .HitCount   (hitA),
    .MissCount  (missA)
`endif
  );

  mips_fetch_controller #(.MEM_LATENCY(4)) dutB (
    .ClockPulse (clk),
    .Reset      (rst),
    .fetchBus   (busB)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .HitCount   (hitB),
    .MissCount  (missB)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign busA.FetchRequest = req;
  assign busA.FetchAddress = addr;
  assign busA.FetchFlush   = flush;
  assign busB.FetchRequest = req;
  assign busB.FetchAddress = addr;
  assign busB.FetchFlush   = flush;

  // Memory: word at byte address A is C0DE0000|A[15:0], line valid MEM_LATENCY edges after address
  function automatic logic [31:0] wordAt(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:2], 2'b00};
  endfunction

  function automatic logic [127:0] lineAt(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) begin
      l[32*k +: 32] = wordAt({a[31:4], 4'h0} + 32'(4 * k));
    end
    return l;
  endfunction

  logic [31:0] pipeA = 32'h0;
  logic [31:0] pipeB [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

  always_ff @(posedge clk) begin
    pipeA    <= busA.MemAddress;
    pipeB[0] <= busB.MemAddress;
    for (int i = 1; i < 4; i++) begin
      pipeB[i] <= pipeB[i-1];
    end
  end

  assign busA.MemLine = lineAt(pipeA);
  assign busB.MemLine = lineAt(pipeB[3]);

  // Reference model state, index 0 = latency 1, index 1 = latency 4
  logic [31:0] mOut     [2];
  logic        mValid   [2];
  logic        mBusy    [2];
  logic [31:0] mMemAddr [2];
  logic        mLineOk  [2];
  logic [27:0] mTag     [2];
  logic [31:0] mReqAddr [2];
  int          mFill    [2];
  int          mHits    [2];
  int          mMiss    [2];

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic modelStep();
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mOut[d] = 32'h0; mValid[d] = 1'b0; mBusy[d] = 1'b0; mMemAddr[d] = 32'h0;
        mLineOk[d] = 1'b0; mHits[d] = 0; mMiss[d] = 0;
      end else begin
        mValid[d] = 1'b0;
        if (flush) begin
          mLineOk[d] = 1'b0;
          mBusy[d]   = 1'b0;
        end else if (mBusy[d]) begin
          if (cyc == mFill[d]) begin
            mLineOk[d] = 1'b1;
            mTag[d]    = mReqAddr[d][31:4];
            mOut[d]    = wordAt(mReqAddr[d]);
            mValid[d]  = 1'b1;
            mBusy[d]   = 1'b0;
          end
        end else if (req) begin
          if (mLineOk[d] && mTag[d] == addr[31:4]) begin
            mOut[d]   = wordAt(addr);
            mValid[d] = 1'b1;
            mHits[d]++;
          end else begin
            mBusy[d]    = 1'b1;
            mReqAddr[d] = addr;
            mFill[d]    = cyc + ((d == 0) ? 1 : 4) + 1;
            mMemAddr[d] = {addr[31:4], 4'h0};
            mMiss[d]++;
          end
        end
      end
    end
  endtask

  task automatic compareAll();
    checkValue("A.valid",   {31'h0, busA.InstructionValid}, {31'h0, mValid[0]});
    checkValue("A.instr",   busA.InstructionOut,            mOut[0]);
    checkValue("A.busy",    {31'h0, busA.FetchBusy},        {31'h0, mBusy[0]});
    checkValue("A.memAddr", busA.MemAddress,                mMemAddr[0]);
    checkValue("B.valid",   {31'h0, busB.InstructionValid}, {31'h0, mValid[1]});
    checkValue("B.instr",   busB.InstructionOut,            mOut[1]);
    checkValue("B.busy",    {31'h0, busB.FetchBusy},        {31'h0, mBusy[1]});
    checkValue("B.memAddr", busB.MemAddress,                mMemAddr[1]);
`ifdef FETCH_PERF_COUNT_EN
    checkValue("A.hits",   {16'h0, hitA},  32'(mHits[0] % 65536));
    checkValue("A.misses", {16'h0, missA}, 32'(mMiss[0] % 65536));
    checkValue("B.hits",   {16'h0, hitB},  32'(mHits[1] % 65536));
    checkValue("B.misses", {16'h0, missB}, 32'(mMiss[1] % 65536));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((mBusy[0] || mBusy[1]) && n < 40) begin
      tick();
      n++;
    end
    if (mBusy[0] || mBusy[1]) begin
      checkValue("idleTimeout", 32'h1, 32'h0);
    end
    tick();
  endtask

  task automatic fetchOne(input logic [31:0] a);
    req  = 1'b1;
    addr = a;
    tick();
    req  = 1'b0;
    waitIdle();
  endtask

  initial begin
    logic [31:0] pool [4];
    pool[0] = 32'h0000_0000;
    pool[1] = 32'h0000_1230;
    pool[2] = 32'hFFFF_FFF0;
    pool[3] = 32'h8000_0040;
    rst = 1'b1; req = 1'b0; flush = 1'b0; addr = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    fetchOne(32'h0000_0008);
    req = 1'b1;
    addr = 32'h0000_0000; tick();
    addr = 32'h0000_0004; tick();
    addr = 32'h0000_000C; tick();
    req = 1'b0; tick();

    fetchOne(32'h0000_0011);
    fetchOne(32'h0000_0021);
    fetchOne(32'h0000_0032);

    // flush one cycle after a miss, then re-request the same line
    req = 1'b1; addr = 32'h0000_0040; tick();
    req = 1'b0; flush = 1'b1; tick();
    flush = 1'b0; tick();
    fetchOne(32'h0000_0040);

    // flush together with a request that would hit
    req = 1'b1; flush = 1'b1; addr = 32'h0000_0044; tick();
    req = 1'b0; flush = 1'b0; tick(); tick();

    // reset during the wait phase
    req = 1'b1; addr = 32'h0000_0050; tick();
    req = 1'b0; tick();
    rst = 1'b1; tick();
    rst = 1'b0; tick();

    // top-of-memory line, then a hit in it
    fetchOne(32'hFFFF_FFFC);
    fetchOne(32'hFFFF_FFF0);

    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      req   = ($urandom_range(0, 1) == 1);
      addr  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; flush = 1'b0; req = 1'b0;
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_fetch_controller.md
# mips_fetch_controller

Instruction-fetch sequencer between the MIPS core's fetch stage and `Mips_Instruction_Memory`. It accepts a 32-bit word fetch request from the core and drives a line-aligned address to the instruction memory. It holds the returned 128-bit line (4 instructions) in a single-line buffer and returns the selected instruction with a one-cycle valid pulse. Requests that hit the buffered line are served without touching the memory.

## Interface
- `MEM_LATENCY`, 1: number of rising edges between `MemAddress` update and `MemLine` being valid; legal 1..8.
- `ClockPulse`  in  1  sole clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `FetchRequest`  in  1  core requests the instruction at `FetchAddress`; sampled only while `FetchBusy`=0.
- `FetchAddress`  in  32  byte address; bits[1:0] ignored.
- `FetchFlush`  in  1  invalidate the line buffer and abort any in-flight miss.
- `InstructionOut`  out  32  returned instruction, registered.
- `InstructionValid`  out  1  one-cycle pulse per completed request.
- `FetchBusy`  out  1  registered; high while a miss is in flight.
- `MemAddress`  out  32  to memory `InstructionAddress`; bits[3:0] always 0.
- `MemLine`  in  128  from memory `OutputInsMemory`; word k = `MemLine[32k+31:32k]`, k = address[3:2].

## Operation
- Internal state: `LineTag` (28 bits, address[31:4]), `LineData` (128 bits), `LineValid`, request word index (2 bits), latency counter.
- FSM states: IDLE, WAIT, FILL.
- IDLE, `FetchRequest`=1, `FetchFlush`=0:
  - Hit (`LineValid` and tag equal): `InstructionOut` gets the selected word of `LineData`, `InstructionValid` pulses, state stays IDLE.
  - Miss: `MemAddress` gets {addr[31:4],4'h0}; the word index is latched; the counter is loaded with `MEM_LATENCY`; `FetchBusy` goes to 1; next state is WAIT.
- WAIT: the counter decrements each edge. Counter reaching 0 moves to FILL.
- FILL: `LineData` gets `MemLine`, `LineTag` is updated, `LineValid` goes to 1, `InstructionOut` gets the latched word, `InstructionValid` pulses, `FetchBusy` goes to 0, next state is IDLE.
- While `FetchBusy`=1, `FetchRequest` and `FetchAddress` are ignored. The core re-issues any request made during that time.
- `FetchFlush`, any state:
  - `LineValid` goes to 0 and the FSM goes to IDLE.
  - No `InstructionValid` is produced for an aborted miss.
  - `MemAddress` holds its value.
  - It has priority over a simultaneous `FetchRequest`, which is dropped.
- `InstructionOut` holds its last value between pulses.
- No address wrap logic is needed. Line 0xFFFFFFF0 is an ordinary line.

## Timing
- Reset values: state IDLE, `LineValid`=0, `InstructionOut`=0, `InstructionValid`=0, `FetchBusy`=0, `MemAddress`=0, counters 0.
- Reset mid-WAIT or mid-FILL: abort with no valid pulse and apply the full reset values.
- Hit latency: `InstructionValid` is high in the cycle after the request edge. Back-to-back hits give one instruction per cycle.
- Miss latency: `MemAddress` updates on the request edge. `InstructionValid` is high exactly `MEM_LATENCY`+1 cycles after the request edge.
- `FetchBusy` is high from the request edge until the FILL edge.
- `MemLine` is sampled only on the FILL edge.

## Configuration
- `FETCH_PERF_COUNT_EN` defined:
  - Adds outputs `HitCount` out 16 and `MissCount` out 16.
  - Each accepted request increments exactly one of them on its acceptance edge. Aborted misses still count as misses.
  - Both counters reset to 0 and wrap from 0xFFFF to 0x0000.
- Not defined: neither port nor any counter logic exists.

## Test plan
Memory model: the word at byte address A is 32'hC0DE0000|A[15:0]; `MEM_LATENCY`=1 unless stated.
- Reset held 3 cycles, then released → all outputs 0, `FetchBusy`=0.
- Cold request to 0x08 → `MemAddress`=0x00 one cycle later; `InstructionValid` pulses 2 cycles after the request with 0xC0DE0008; `FetchBusy` is high for those 2 cycles.
- Back-to-back hits to 0x00, 0x04, 0x0C → three consecutive pulses 0xC0DE0000, 0xC0DE0004, 0xC0DE000C; `MemAddress` unchanged.
- Requests 0x11, 0x21, 0x32 → each misses; `MemAddress` is 0x10, 0x20, 0x30 and the data is 0xC0DE0010, 0xC0DE0020, 0xC0DE0030.
  - Repeat with `MEM_LATENCY`=4 → each valid pulse comes 5 cycles after its request.
- `FetchFlush` one cycle after a miss to 0x40 → no valid pulse and `FetchBusy`=0. A re-request to 0x40 misses again.
  - Flush plus request in the same cycle → no pulse.
- `Reset` asserted during WAIT → no pulse and reset values. With `FETCH_PERF_COUNT_EN`, after 3 misses and 2 hits → `MissCount`=3, `HitCount`=2.
